// File: rtl/frame_buffer_rotator.sv
// frame_buffer_rotator: routes producer/consumer onto NUM_BUFS (2 or 3) image buffers and rotates roles
// Optional statistics counters are enabled with `define FB_STATS_EN.
module frame_buffer_rotator #(
    parameter int NUM_BUFS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_req,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_ready,
    input  logic                           rd_req,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_ready,
    input  logic                           streaming_ended,
    input  logic                           frame_ended,
    output logic [NUM_BUFS-1:0]            ram_req,
    output logic [NUM_BUFS-1:0]            ram_we,
    output logic [NUM_BUFS*ADDR_WIDTH-1:0] ram_addr,
    output logic [NUM_BUFS*DATA_WIDTH-1:0] ram_wdata,
    input  logic [NUM_BUFS*DATA_WIDTH-1:0] ram_rdata,
    input  logic [NUM_BUFS-1:0]            ram_ready,
    output logic [1:0]                     front_idx,
    output logic [1:0]                     back_idx,
    output logic                           producer_stall,
    output logic                           swap_done
`ifdef FB_STATS_EN
    ,
    output logic [15:0]                    swap_count,
    output logic [15:0]                    drop_count
`endif
);

    generate
        if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
            $error("frame_buffer_rotator: NUM_BUFS must be 2 or 3");
        end
    endgenerate

    logic [1:0] spare_idx;
    logic       pending_valid;
    logic       swap_req;
    logic [1:0] front_n;
    logic [1:0] back_n;
    logic [1:0] spare_n;
    logic       pending_n;
    logic       swap_req_n;
    logic       stall_n;
    logic       swap_n;
    logic       drop;

    // next role assignment from the end-of-frame / end-of-stream pulses
    always_comb begin
        front_n    = front_idx;
        back_n     = back_idx;
        spare_n    = spare_idx;
        pending_n  = pending_valid;
        swap_req_n = swap_req;
        stall_n    = producer_stall;
        swap_n     = 1'b0;
        drop       = 1'b0;
        if (NUM_BUFS == 2) begin
            pending_n = 1'b0;
            if (swap_req) begin
                if (frame_ended) begin
                    front_n    = back_idx;
                    back_n     = front_idx;
                    swap_req_n = 1'b0;
                    stall_n    = 1'b0;
                    swap_n     = 1'b1;
                end
            end else if (streaming_ended && frame_ended) begin
                front_n = back_idx;
                back_n  = front_idx;
                swap_n  = 1'b1;
            end else if (streaming_ended) begin
                swap_req_n = 1'b1;
                stall_n    = 1'b1;
            end
        end else begin
            swap_req_n = 1'b0;
            stall_n    = 1'b0;
            if (streaming_ended && frame_ended) begin
                front_n   = back_idx;
                back_n    = front_idx;
                pending_n = 1'b0;
                swap_n    = 1'b1;
                drop      = pending_valid;
            end else if (streaming_ended) begin
                back_n    = spare_idx;
                spare_n   = back_idx;
                pending_n = 1'b1;
                drop      = pending_valid;
            end else if (frame_ended && pending_valid) begin
                front_n   = spare_idx;
                spare_n   = front_idx;
                pending_n = 1'b0;
                swap_n    = 1'b1;
            end
        end
    end

    // role state register
    always_ff @(posedge clk) begin
        if (reset) begin
            front_idx      <= 2'd0;
            back_idx       <= 2'd1;
            spare_idx      <= 2'd2;
            pending_valid  <= 1'b0;
            swap_req       <= 1'b0;
            producer_stall <= 1'b0;
            swap_done      <= 1'b0;
        end else begin
            front_idx      <= front_n;
            back_idx       <= back_n;
            spare_idx      <= spare_n;
            pending_valid  <= pending_n;
            swap_req       <= swap_req_n;
            producer_stall <= stall_n;
            swap_done      <= swap_n;
        end
    end

`ifdef FB_STATS_EN
    // swap and dropped-frame counters, both wrap at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            swap_count <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            swap_count <= swap_count + 16'(swap_n);
            drop_count <= drop_count + 16'(drop);
        end
    end
`endif

    // buffer routing from registered roles; requests are blocked while reset is held
    always_comb begin
        ram_req   = '0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (2'(i) == front_idx) begin
                ram_req[i]                           = rd_req & ~reset;
                ram_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr;
            end else if (2'(i) == back_idx) begin
                ram_req[i]                           = wr_req & ~reset;
                ram_we[i]                            = ~reset;
                ram_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr;
                ram_wdata[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
            end
        end
        rd_data  = ram_rdata[front_idx*DATA_WIDTH +: DATA_WIDTH];
        rd_ready = ram_ready[front_idx];
        wr_ready = ram_ready[back_idx];
    end

endmodule

// File: tb/tb_frame_buffer_rotator.sv
// tb_frame_buffer_rotator: scoreboard bench running a double- and a triple-buffer instance on shared stimulus
module tb_frame_buffer_rotator;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          streaming_ended = 1'b0;
    logic          frame_ended = 1'b0;
    logic [23:0]   rdata3 = '0;
    logic [2:0]    ready3 = '0;

    logic          wr_ready2, rd_ready2, stall2, swap_done2;
    logic [DW-1:0] rd_data2;
    logic [1:0]    req2, we2, front2, back2;
    logic [31:0]   addr2;
    logic [15:0]   wdata2;
    logic          wr_ready3, rd_ready3, stall3, swap_done3;
    logic [DW-1:0] rd_data3;
    logic [2:0]    req3, we3;
    logic [1:0]    front3, back3;
    logic [47:0]   addr3;
    logic [23:0]   wdata3;
    logic [15:0]   swc2, drc2, swc3, drc3;

    always #5 clk = ~clk;

    frame_buffer_rotator #(.NUM_BUFS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u2 (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready2), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data2),
        .rd_ready(rd_ready2), .streaming_ended(streaming_ended), .frame_ended(frame_ended),
        .ram_req(req2), .ram_we(we2), .ram_addr(addr2), .ram_wdata(wdata2),
        .ram_rdata(rdata3[15:0]), .ram_ready(ready3[1:0]), .front_idx(front2), .back_idx(back2),
        .producer_stall(stall2), .swap_done(swap_done2)
`ifdef FB_STATS_EN
        , .swap_count(swc2), .drop_count(drc2)
`endif
    );

    frame_buffer_rotator #(.NUM_BUFS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u3 (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready3), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data3),
        .rd_ready(rd_ready3), .streaming_ended(streaming_ended), .frame_ended(frame_ended),
        .ram_req(req3), .ram_we(we3), .ram_addr(addr3), .ram_wdata(wdata3),
        .ram_rdata(rdata3), .ram_ready(ready3), .front_idx(front3), .back_idx(back3),
        .producer_stall(stall3), .swap_done(swap_done3)
`ifdef FB_STATS_EN
        , .swap_count(swc3), .drop_count(drc3)
`endif
    );

`ifndef FB_STATS_EN
    assign swc2 = '0;
    assign drc2 = '0;
    assign swc3 = '0;
    assign drc3 = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  f2 = 0, b2 = 1, f3 = 0, b3 = 1, s3 = 2;
    logic        st2 = 0, sr2 = 0, sd2 = 0, pv3 = 0, sd3 = 0;
    logic [15:0] msw2 = 0, msw3 = 0, mdr3 = 0;
    logic [37:0] q2[$];
    logic [37:0] q3[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_route(input string tag, input int n, input logic [1:0] f, input logic [1:0] b,
                               input logic [2:0] req, input logic [2:0] we, input logic [47:0] addr,
                               input logic [23:0] wd, input logic [7:0] rdd, input logic rdy,
                               input logic wrdy);
        logic [2:0]  ereq = '0;
        logic [2:0]  ewe = '0;
        logic [47:0] eaddr = '0;
        logic [23:0] ewd = '0;
        for (int i = 0; i < n; i++) begin
            if (i == int'(f)) begin
                ereq[i] = rd_req & ~reset;
                eaddr[i*AW +: AW] = rd_addr;
            end
            if (i == int'(b)) begin
                ereq[i] = wr_req & ~reset;
                ewe[i] = ~reset;
                eaddr[i*AW +: AW] = wr_addr;
                ewd[i*DW +: DW] = wr_data;
            end
        end
        check({tag, "_req"}, 64'(req), 64'(ereq));
        check({tag, "_we"}, 64'(we), 64'(ewe));
        check({tag, "_addr"}, 64'(addr), 64'(eaddr));
        check({tag, "_wdata"}, 64'(wd), 64'(ewd));
        check({tag, "_rd_data"}, 64'(rdd), 64'(rdata3[int'(f)*DW +: DW]));
        check({tag, "_rd_ready"}, 64'(rdy), 64'(ready3[f]));
        check({tag, "_wr_ready"}, 64'(wrdy), 64'(ready3[b]));
    endtask

    task automatic model_update(input logic r, input logic s, input logic f);
        logic [1:0] t;
        sd2 = 0;
        sd3 = 0;
        if (r) begin
            f2 = 0; b2 = 1; st2 = 0; sr2 = 0;
            f3 = 0; b3 = 1; s3 = 2; pv3 = 0;
            msw2 = 0; msw3 = 0; mdr3 = 0;
        end else begin
            if ((sr2 && f) || (!sr2 && s && f)) begin
                t = f2; f2 = b2; b2 = t; sr2 = 0; st2 = 0; sd2 = 1;
            end else if (!sr2 && s) begin
                sr2 = 1; st2 = 1;
            end
            if (s && f) begin
                if (pv3) mdr3++;
                t = f3; f3 = b3; b3 = t; pv3 = 0; sd3 = 1;
            end else if (s) begin
                if (pv3) mdr3++;
                t = b3; b3 = s3; s3 = t; pv3 = 1;
            end else if (f && pv3) begin
                t = f3; f3 = s3; s3 = t; pv3 = 0; sd3 = 1;
            end
            if (sd2) msw2++;
            if (sd3) msw3++;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f);
        logic [37:0] e;
        @(negedge clk);
        reset = r;
        streaming_ended = s;
        frame_ended = f;
        wr_req = 1'($urandom);
        rd_req = 1'($urandom);
        wr_addr = AW'($urandom);
        rd_addr = AW'($urandom);
        wr_data = DW'($urandom);
        rdata3 = 24'($urandom);
        ready3 = 3'($urandom);
        #1;
        check_route("n2", 2, f2, b2, {1'b0, req2}, {1'b0, we2}, {16'd0, addr2}, {8'd0, wdata2},
                    rd_data2, rd_ready2, wr_ready2);
        check_route("n3", 3, f3, b3, req3, we3, addr3, wdata3, rd_data3, rd_ready3, wr_ready3);
        @(posedge clk);
        model_update(r, s, f);
        q2.push_back({msw2, 16'd0, f2, b2, st2, sd2});
        q3.push_back({msw3, mdr3, f3, b3, 1'b0, sd3});
        #1;
        e = q2.pop_front();
        check("n2_front", 64'(front2), 64'(e[5:4]));
        check("n2_back", 64'(back2), 64'(e[3:2]));
        check("n2_stall", 64'(stall2), 64'(e[1]));
        check("n2_swap_done", 64'(swap_done2), 64'(e[0]));
        e = q3.pop_front();
        check("n3_front", 64'(front3), 64'(e[5:4]));
        check("n3_back", 64'(back3), 64'(e[3:2]));
        check("n3_stall", 64'(stall3), 64'(e[1]));
        check("n3_swap_done", 64'(swap_done3), 64'(e[0]));
`ifdef FB_STATS_EN
        e = {q2.size() == 0 ? {msw2, 16'd0} : 32'd0, 6'd0};
        check("n2_swap_count", 64'(swc2), 64'(msw2));
        check("n2_drop_count", 64'(drc2), 64'd0);
        check("n3_swap_count", 64'(swc3), 64'(msw3));
        check("n3_drop_count", 64'(drc3), 64'(mdr3));
`endif
    endtask

    initial begin
        step(1, 0, 0);
        step(1, 0, 0);
        @(negedge clk);
        reset = 0;
        wr_req = 1;
        wr_addr = 5;
        wr_data = 8'hA5;
        rd_req = 0;
        #1;
        check("t1_req", 64'(req2), 64'(2'b10));
        check("t1_we1", 64'(we2[1]), 64'd1);
        check("t1_addr1", 64'(addr2[AW +: AW]), 64'd5);
        check("t1_wdata1", 64'(wdata2[DW +: DW]), 64'hA5);
        check("t1_wdata0", 64'(wdata2[0 +: DW]), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 1, 0);
        check("t2_stall_set", 64'(stall2), 64'd1);
        for (int i = 0; i < 9; i++) step(0, 0, 0);
        step(0, 0, 1);
        check("t2_front_swapped", 64'(front2), 64'd1);
        step(0, 1, 1);
        check("t3_front", 64'(front2), 64'd0);
        check("t3_no_stall", 64'(stall2), 64'd0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        check("t4_n3_back", 64'(back3), 64'd1);
        step(0, 0, 1);
        check("t4_n3_front", 64'(front3), 64'd2);
        check("t4_n2_front", 64'(front2), 64'd1);
`ifdef FB_STATS_EN
        check("t4_n3_drops", 64'(drc3), 64'd1);
`endif
        @(negedge clk);
        streaming_ended = 0;
        frame_ended = 0;
        rd_req = 1;
        wr_req = 1;
        rdata3 = 24'h3C0000;
        ready3 = 3'b100;
        #1;
        check("t5_rd_data", 64'(rd_data3), 64'h3C);
        check("t5_rd_ready", 64'(rd_ready3), 64'd1);
        check("t5_spare_req", 64'(req3[0]), 64'd0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        check("t6_front", 64'(front2), 64'd0);
        check("t6_stall", 64'(stall2), 64'd0);
        step(0, 0, 1);
        check("t6_no_swap", 64'(front2), 64'd0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
